mouse_pointer: RTL and testbench
================================

Name: mouse_pointer

Overview:
Consumes the 28-bit packed PS/2 mouse status word (run flag, buttons, free-running 11-bit X/Y accumulators). Converts the accumulators into a screen-bounded pointer position. Emits change events into a small valid/ready FIFO for the CPU or video cursor logic. Sits directly downstream of the PS/2 mouse receiver, in the same clock domain.

Parameters:
H_RES, 640, visible width in pixels; ptr_x range 0..H_RES-1 (H_RES <= 2047)
V_RES, 480, visible height in pixels; ptr_y range 0..V_RES-1 (V_RES <= 2047)
FIFO_DEPTH, 4, event FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mouse_data  in  28  [27]=run, [26:24]=btns, [23]=0, [22:12]=y accum, [11]=0, [10:0]=x accum
ptr_x  out  11  clamped pointer X
ptr_y  out  11  clamped pointer Y, screen-down positive
ptr_btns  out  3  current buttons
ptr_active  out  1  registered copy of run
evt_valid  out  1  FIFO head valid
evt_data  out  25  {btns[2:0], ptr_y[10:0], ptr_x[10:0]}
evt_ready  in  1  consumer pops head when evt_valid & evt_ready
evt_ovf  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values: ptr_x=H_RES/2, ptr_y=V_RES/2, ptr_btns=0, ptr_active=0, evt_valid=0, evt_ovf=0, FIFO empty, prev_x=prev_y=0, prev_btns=0.
- Stage 1 (every cycle): register mouse_data into in_q, which holds run_q, btns_q, x_q, y_q. prev_* hold the in_q values of the previous cycle.
- Idle (run_q=0):
  - pointer recentres to (H_RES/2, V_RES/2) and ptr_btns=0.
  - prev_* track in_q; no events are generated.
  - FIFO contents are retained.
- First cycle with run_q=1 after run_q=0: prev_* are loaded with in_q; no event is generated.
- Tracking (run_q=1, prev valid):
  - dx = x_q - prev_x and dy = y_q - prev_y, computed modulo 2^11 and read as signed (-1024..+1023). Accumulator wrap 2047->0 therefore gives +1.
  - nx = ptr_x + dx and ny = ptr_y - dy, computed in 13-bit signed. PS/2 Y is up-positive, hence the subtraction.
  - Clamp each: <0 -> 0; >RES-1 -> RES-1.
  - ptr_* update at the end of that cycle.
- Event condition: tracking and (dx!=0 or dy!=0 or btns_q!=prev_btns).
  - Push {btns_q, clamped ny, clamped nx} in the same cycle the pointer updates.
  - A move fully absorbed by a clamp still pushes an event with unchanged coordinates.
- Latency: mouse_data change at edge N -> in_q at N+1 -> ptr_*/FIFO write at N+2 -> evt_valid high after edge N+2 if the FIFO was empty.
- FIFO: synchronous, show-ahead; evt_data is valid whenever evt_valid=1.
  - Pop: evt_valid & evt_ready.
  - Push when full without a simultaneous pop: the new event is dropped, evt_ovf <= 1, and the existing contents are unchanged.
  - Push when full with a simultaneous pop: both happen; no drop, occupancy stays FIFO_DEPTH.
  - Push into empty with a simultaneous evt_ready: no bypass; the new entry appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- evt_ovf clears only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk; any pending events are lost.

Decomposition:
- Package mouse_pkg:
  - field offsets and widths of the 28-bit mouse word (RUN_BIT=27, BTN_LSB=24, Y_LSB=12, X_LSB=0, COORD_W=11)
  - EVT_W=25
  - event field offsets
- One sub-module, mouse_evt_fifo: parameterised width/depth show-ahead FIFO with push/pop/full/empty and async reset.
- Delta, clamp and event detect stay in mouse_pointer.

Test Plan:
1. Assert reset mid-stream with FIFO holding 2 events -> immediately ptr=(320,240), evt_valid=0, evt_ovf=0.
2. run 0->1 with x=y=0, then x=5 -> no event on entry; then ptr_x=325, ptr_y=240, one event evt_data={3'b000, 11'd240, 11'd325}.
3. Wrap: x accumulator 2045 -> 3 -> dx=+6; ptr_x 320 -> 326. y accumulator 0 -> 2047 -> dy=-1; ptr_y 240 -> 241.
4. Clamp: x +1000 from 320 -> ptr_x=639; y +300 from 240 -> ptr_y=0. Further +10 x -> event with ptr_x still 639.
5. evt_ready=0, five movement events -> evt_valid=1, four entries held in order, 5th dropped, evt_ovf=1. Then evt_ready=1 -> four pops in order, evt_valid=0, evt_ovf stays 1.
6. Buttons only 000 -> 001 (left) -> one event {3'b001, 240, 320}, ptr unchanged. run -> 0 -> ptr recentres, ptr_btns=0, no event.

Source files
------------

// File: rtl/mouse_pkg.sv
// Field layout of the packed PS/2 mouse status word and the pointer event word,
// plus the screen-edge clamp shared by both axes.
package mouse_pkg;

  localparam int unsigned MOUSE_W     = 28;
  localparam int unsigned RUN_BIT     = 27;
  localparam int unsigned BTN_LSB     = 24;
  localparam int unsigned BTN_W       = 3;
  localparam int unsigned Y_LSB       = 12;
  localparam int unsigned X_LSB       = 0;
  localparam int unsigned COORD_W     = 11;
  localparam int unsigned CALC_W      = COORD_W + 2;

  localparam int unsigned EVT_W       = 25;
  localparam int unsigned EVT_X_LSB   = 0;
  localparam int unsigned EVT_Y_LSB   = 11;
  localparam int unsigned EVT_BTN_LSB = 22;

  // Saturate a signed candidate coordinate into 0..max_v.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [CALC_W-1:0] v,
                                                     input logic [COORD_W-1:0] max_v);
    logic signed [CALC_W-1:0] lim;
    lim = $signed({2'b00, max_v});
    if (v[CALC_W-1]) return '0;
    if (v > lim)     return max_v;
    return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/mouse_evt_fifo.sv
// Show-ahead FIFO for pointer events; push into a full FIFO is ignored unless a
// pop happens in the same cycle.
import mouse_pkg::*;

module mouse_evt_fifo #(
  parameter int unsigned WIDTH = EVT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mouse_pointer.sv
// Turns free-running PS/2 X/Y accumulators into a screen-bounded pointer and
// queues a change event whenever the pointer or buttons change.
import mouse_pkg::*;

module mouse_pointer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MOUSE_W-1:0]   mouse_data,
  output logic [COORD_W-1:0]   ptr_x,
  output logic [COORD_W-1:0]   ptr_y,
  output logic [BTN_W-1:0]     ptr_btns,
  output logic                 ptr_active,
  output logic                 evt_valid,
  output logic [EVT_W-1:0]     evt_data,
  input  logic                 evt_ready,
  output logic                 evt_ovf
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] X_MID = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] Y_MID = COORD_W'(V_RES / 2);

  logic               run_q;
  logic [BTN_W-1:0]   btns_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               prev_run;
  logic [BTN_W-1:0]   prev_btns;
  logic [COORD_W-1:0] prev_x;
  logic [COORD_W-1:0] prev_y;

  logic                     tracking;
  logic [COORD_W-1:0]       dx;
  logic [COORD_W-1:0]       dy;
  logic signed [CALC_W-1:0] nx;
  logic signed [CALC_W-1:0] ny;
  logic [COORD_W-1:0]       nx_c;
  logic [COORD_W-1:0]       ny_c;
  logic                     push;
  logic [EVT_W-1:0]         push_data;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     unused_pad;

  assign unused_pad = ^{mouse_data[Y_LSB-1], mouse_data[BTN_LSB-1]};

  // prev_* always follow in_q; prev_run marks whether they hold a running sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      btns_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      prev_run  <= 1'b0;
      prev_btns <= '0;
      prev_x    <= '0;
      prev_y    <= '0;
    end else begin
      run_q     <= mouse_data[RUN_BIT];
      btns_q    <= mouse_data[BTN_LSB +: BTN_W];
      y_q       <= mouse_data[Y_LSB +: COORD_W];
      x_q       <= mouse_data[X_LSB +: COORD_W];
      prev_run  <= run_q;
      prev_btns <= btns_q;
      prev_x    <= x_q;
      prev_y    <= y_q;
    end
  end

  // Deltas wrap in 11 bits, then sign-extend; PS/2 Y is up-positive, screen Y is down.
  always_comb begin
    tracking = run_q & prev_run;
    dx       = x_q - prev_x;
    dy       = y_q - prev_y;
    nx       = $signed({2'b00, ptr_x}) + $signed({{2{dx[COORD_W-1]}}, dx});
    ny       = $signed({2'b00, ptr_y}) - $signed({{2{dy[COORD_W-1]}}, dy});
    nx_c     = clamp_coord(nx, X_MAX);
    ny_c     = clamp_coord(ny, Y_MAX);
    push     = tracking & ((dx != '0) | (dy != '0) | (btns_q != prev_btns));
    push_data = '0;
    push_data[EVT_X_LSB +: COORD_W] = nx_c;
    push_data[EVT_Y_LSB +: COORD_W] = ny_c;
    push_data[EVT_BTN_LSB +: BTN_W] = btns_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_x      <= X_MID;
      ptr_y      <= Y_MID;
      ptr_btns   <= '0;
      ptr_active <= 1'b0;
    end else begin
      ptr_active <= run_q;
      if (!run_q) begin
        ptr_x    <= X_MID;
        ptr_y    <= Y_MID;
        ptr_btns <= '0;
      end else begin
        ptr_btns <= btns_q;
        if (tracking) begin
          ptr_x <= nx_c;
          ptr_y <= ny_c;
        end
      end
    end
  end

  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_ovf <= 1'b0;
    end else if (push & full & ~pop) begin
      evt_ovf <= 1'b1;
    end
  end

  mouse_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (evt_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_mouse_pointer.sv
// Directed bench for mouse_pointer: an integer/queue model of the pointer and
// event stream is compared every cycle, plus literal checks on key scenarios.
module tb_mouse_pointer;

  localparam int H = 640;
  localparam int V = 480;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] mouse_data = '0;
  logic        evt_ready = 1'b0;
  logic [10:0] ptr_x;
  logic [10:0] ptr_y;
  logic [2:0]  ptr_btns;
  logic        ptr_active;
  logic        evt_valid;
  logic [24:0] evt_data;
  logic        evt_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mouse_pointer #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mouse_data (mouse_data),
    .ptr_x      (ptr_x),
    .ptr_y      (ptr_y),
    .ptr_btns   (ptr_btns),
    .ptr_active (ptr_active),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .evt_ovf    (evt_ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input int run, input int btns, input int y, input int x);
    return {1'(run), 3'(btns), 1'b0, 11'(y), 1'b0, 11'(x)};
  endfunction

  function automatic int pack_evt(input int btns, input int y, input int x);
    return (btns << 22) | (y << 11) | x;
  endfunction

  // Model: the sampled word, the previous sample, pointer and an event queue.
  int m_run, m_btns, m_x, m_y;
  int p_run, p_btns, p_x, p_y;
  int m_px, m_py, m_pb, m_act, m_ovf;
  int q[$];

  always @(posedge clk or posedge reset) begin : model
    int dx, dy, nx, ny;
    bit pop, ev;
    if (reset) begin
      m_run = 0; m_btns = 0; m_x = 0; m_y = 0;
      p_run = 0; p_btns = 0; p_x = 0; p_y = 0;
      m_px = H / 2; m_py = V / 2; m_pb = 0; m_act = 0; m_ovf = 0;
      q.delete();
    end else begin
      pop = (q.size() > 0) && evt_ready;
      ev  = 0;
      dx = (m_x - p_x) & 2047; if (dx >= 1024) dx -= 2048;
      dy = (m_y - p_y) & 2047; if (dy >= 1024) dy -= 2048;
      if (m_run == 0) begin
        m_px = H / 2; m_py = V / 2; m_pb = 0;
      end else begin
        if (p_run != 0) begin
          nx = m_px + dx;
          ny = m_py - dy;
          if (nx < 0) nx = 0; else if (nx > H - 1) nx = H - 1;
          if (ny < 0) ny = 0; else if (ny > V - 1) ny = V - 1;
          ev = (dx != 0) || (dy != 0) || (m_btns != p_btns);
          m_px = nx; m_py = ny;
        end
        m_pb = m_btns;
      end
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() >= D) m_ovf = 1;
        else q.push_back(pack_evt(m_btns, m_py, m_px));
      end
      m_act = m_run;
      p_run = m_run; p_btns = m_btns; p_x = m_x; p_y = m_y;
      m_run  = int'(mouse_data[27]);
      m_btns = int'(mouse_data[26:24]);
      m_y    = int'(mouse_data[22:12]);
      m_x    = int'(mouse_data[10:0]);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ptr_x", ptr_x, m_px);
      check("ptr_y", ptr_y, m_py);
      check("ptr_btns", ptr_btns, m_pb);
      check("ptr_active", ptr_active, m_act);
      check("evt_valid", evt_valid, (q.size() > 0) ? 1 : 0);
      check("evt_ovf", evt_ovf, m_ovf);
      if (q.size() > 0) check("evt_data", evt_data, q[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter(input int x, input int y);
    mouse_data = mk(0, 0, y, x);
    tick(2);
    mouse_data = mk(1, 0, y, x);
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [24:0] exp;
    tick(2);
    check("rst ptr_x", ptr_x, 320);
    check("rst ptr_y", ptr_y, 240);
    check("rst evt_valid", evt_valid, 0);
    reset = 1'b0;

    // Two events queued, then reset between clock edges.
    mouse_data = mk(1, 0, 0, 0);
    tick(2);
    mouse_data = mk(1, 0, 0, 5);
    tick(1);
    mouse_data = mk(1, 0, 0, 10);
    tick(2);
    check("pre-rst evt_valid", evt_valid, 1);
    #3 reset = 1'b1;
    #1;
    check("midrst ptr_x", ptr_x, 320);
    check("midrst ptr_y", ptr_y, 240);
    check("midrst evt_valid", evt_valid, 0);
    check("midrst evt_ovf", evt_ovf, 0);
    mouse_data = '0;
    @(negedge clk);
    reset = 1'b0;

    // Run entry then +5 in X.
    evt_ready = 1'b1;
    mouse_data = mk(1, 0, 0, 0);
    tick(2);
    check("entry no event", evt_valid, 0);
    mouse_data = mk(1, 0, 0, 5);
    tick(2);
    check("move ptr_x", ptr_x, 325);
    check("move ptr_y", ptr_y, 240);
    check("move evt_valid", evt_valid, 1);
    exp = {3'b000, 11'd240, 11'd325};
    check("move evt_data", evt_data, exp);

    // Accumulator wrap in both axes.
    enter(2045, 0);
    mouse_data = mk(1, 0, 2047, 3);
    tick(2);
    check("wrap ptr_x", ptr_x, 326);
    check("wrap ptr_y", ptr_y, 241);

    // Clamp at right and top edges, then a fully absorbed move.
    enter(0, 0);
    mouse_data = mk(1, 0, 300, 1000);
    tick(2);
    check("clamp ptr_x", ptr_x, 639);
    check("clamp ptr_y", ptr_y, 0);
    mouse_data = mk(1, 0, 300, 1010);
    tick(2);
    check("absorbed ptr_x", ptr_x, 639);
    check("absorbed evt_valid", evt_valid, 1);
    exp = {3'b000, 11'd0, 11'd639};
    check("absorbed evt_data", evt_data, exp);

    // Overflow: five events into a four-deep FIFO with no consumer.
    enter(0, 0);
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mouse_data = mk(1, 0, 0, i);
      tick(1);
    end
    tick(2);
    check("ovf evt_ovf", evt_ovf, 1);
    check("ovf evt_valid", evt_valid, 1);
    check("ovf ptr_x", ptr_x, 325);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = {3'b000, 11'd240, 11'(321 + i)};
      check($sformatf("drain[%0d]", i), evt_data, exp);
      tick(1);
    end
    check("drained evt_valid", evt_valid, 0);
    check("drained evt_ovf", evt_ovf, 1);

    // Button-only change, then stop.
    enter(0, 0);
    mouse_data = mk(1, 1, 0, 0);
    tick(2);
    check("btn evt_valid", evt_valid, 1);
    exp = {3'b001, 11'd240, 11'd320};
    check("btn evt_data", evt_data, exp);
    check("btn ptr_x", ptr_x, 320);
    check("btn ptr_btns", ptr_btns, 1);
    mouse_data = mk(0, 1, 0, 0);
    tick(2);
    check("stop ptr_x", ptr_x, 320);
    check("stop ptr_y", ptr_y, 240);
    check("stop ptr_btns", ptr_btns, 0);
    check("stop ptr_active", ptr_active, 0);
    check("stop evt_valid", evt_valid, 0);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
